// File: rtl/key_loader.sv
// Serial key loader: receives a key MSB-first plus an XOR checksum and drives the key bus atomically.
// Optional lockout after repeated checksum failures is built when KEY_LOADER_LOCKOUT_EN is defined.
module key_loader #(
  parameter int KEY_W    = 32,
  parameter int MAX_FAIL = 3,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_ok,
  output logic             busy,
  output logic             err,
  output logic             locked,
  output logic [1:0]       fail_cnt
);

  if (KEY_W < 8 || (KEY_W % 8) != 0 || MAX_FAIL < 1 || (2 ** CNT_W) <= (KEY_W + 8)) begin : gBadParams
    $error("key_loader: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SUM,
`ifdef KEY_LOADER_LOCKOUT_EN
    LOCK,
`endif
    CHECK
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] shreg_q;
  logic [7:0]       sum_q;
  logic [KEY_W-1:0] keyinput_q;
  logic             key_ok_q;
  logic             busy_q;
  logic             err_q;
  logic             ready_q;
  logic [1:0]       fail_cnt_q;
  logic [7:0]       calc_d;
  logic [1:0]       fail_cnt_d;
  logic             accept;

  assign accept = sdi_valid && ready_q;

  always_comb begin
    calc_d = '0;
    for (int i = 0; i < KEY_W / 8; i++) begin
      calc_d = calc_d ^ shreg_q[i*8 +: 8];
    end
  end

  assign fail_cnt_d = (fail_cnt_q == 2'd3) ? 2'd3 : fail_cnt_q + 2'd1;

`ifdef KEY_LOADER_LOCKOUT_EN
  logic locked_q;
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  // One counter spans key and checksum bits, so it stays below 2**CNT_W for the whole load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      sum_q      <= '0;
      keyinput_q <= '0;
      key_ok_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      fail_cnt_q <= '0;
`ifdef KEY_LOADER_LOCKOUT_EN
      locked_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
            sum_q   <= '0;
          end
        end
        SHIFT: begin
          if (accept) begin
            shreg_q <= {shreg_q[KEY_W-2:0], sdi};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(KEY_W - 1)) begin
              state_q <= SUM;
            end
          end
        end
        SUM: begin
          if (accept) begin
            sum_q <= {sum_q[6:0], sdi};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(KEY_W + 7)) begin
              state_q <= CHECK;
              ready_q <= 1'b0;
            end
          end
        end
        CHECK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (calc_d == sum_q) begin
            keyinput_q <= shreg_q;
            key_ok_q   <= 1'b1;
            fail_cnt_q <= '0;
            err_q      <= 1'b0;
          end else begin
            keyinput_q <= '0;
            key_ok_q   <= 1'b0;
            err_q      <= 1'b1;
            fail_cnt_q <= fail_cnt_d;
`ifdef KEY_LOADER_LOCKOUT_EN
            if (32'(fail_cnt_d) >= MAX_FAIL) begin
              state_q  <= LOCK;
              locked_q <= 1'b1;
            end
`endif
          end
        end
`ifdef KEY_LOADER_LOCKOUT_EN
        LOCK: begin
          keyinput_q <= '0;
          key_ok_q   <= 1'b0;
          locked_q   <= 1'b1;
        end
`endif
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sdi_ready = ready_q;
  assign keyinput  = keyinput_q;
  assign key_ok    = key_ok_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: good/bad loads, stalls, lockout (per build), mid-load reset and stray starts.
module tb_key_loader;

   localparam int KEY_W = 32;

   logic             clock;
   logic             reset;
   logic             start;
   logic             sdi;
   logic             sdiValid;
   logic             sdiReady;
   logic [KEY_W-1:0] keyInput;
   logic             keyOk;
   logic             busy;
   logic             err;
   logic             locked;
   logic [1:0]       failCnt;

   int assertCount = 0;
   int failCount   = 0;

   key_loader #(.KEY_W(KEY_W), .MAX_FAIL(3), .CNT_W(6)) dut (
      .clk      (clock),
      .rst      (reset),
      .start    (start),
      .sdi      (sdi),
      .sdi_valid(sdiValid),
      .sdi_ready(sdiReady),
      .keyinput (keyInput),
      .key_ok   (keyOk),
      .busy     (busy),
      .err      (err),
      .locked   (locked),
      .fail_cnt (failCnt)
   );

   // Free-running clock, 10 ns period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Presents one bit (after an optional stall with garbage data) and waits until it is accepted
   task automatic applyStimulus(input logic b, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         sdiValid = 1'b0;
         sdi      = ~b;
         @(negedge clock);
      end
      sdi      = b;
      sdiValid = 1'b1;
      t        = 0;
      while (!sdiReady && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!sdiReady) begin
         assertCount++;
         failCount++;
         $error("[TB] FAIL readyTimeout: observed sdi_ready 0 expected 1 within 50 cycles");
      end else begin
         @(negedge clock);
      end
      sdiValid = 1'b0;
   endtask

   // Full load: start pulse, key MSB-first, then checksum; returns at the negedge in CHECK
   task automatic loadKey(input logic [31:0] key, input logic [7:0] sum, input int gapMax, input int startAt);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("busyAtStart", {31'b0, busy}, 32'd1);
      for (int i = KEY_W - 1; i >= 0; i--) begin
         if ((KEY_W - 1 - i) == startAt) start = 1'b1;
         applyStimulus(key[i], (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0);
         start = 1'b0;
      end
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(sum[i], (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0);
      end
   endtask

   // Test sequence
   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      sdi      = 1'b0;
      sdiValid = 1'b0;
      #2;
      checkOutput("rstKey",    keyInput, 32'h0);
      checkOutput("rstKeyOk",  {31'b0, keyOk}, 32'd0);
      checkOutput("rstBusy",   {31'b0, busy}, 32'd0);
      checkOutput("rstErr",    {31'b0, err}, 32'd0);
      checkOutput("rstLocked", {31'b0, locked}, 32'd0);
      checkOutput("rstFail",   {30'b0, failCnt}, 32'd0);
      checkOutput("rstReady",  {31'b0, sdiReady}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Good load, no stalls, with one-cycle latency check
      loadKey(32'hDEADBEEF, 8'h22, 0, -1);
      checkOutput("latencyKey",   keyInput, 32'h0);
      checkOutput("latencyReady", {31'b0, sdiReady}, 32'd0);
      @(negedge clock);
      checkOutput("good1Key",  keyInput, 32'hDEADBEEF);
      checkOutput("good1Ok",   {31'b0, keyOk}, 32'd1);
      checkOutput("good1Err",  {31'b0, err}, 32'd0);
      checkOutput("good1Busy", {31'b0, busy}, 32'd0);

      // Good load with random stalls; start held during CHECK must be ignored
      loadKey(32'h12345678, 8'h08, 3, -1);
      checkOutput("stallKeyHeld", keyInput, 32'hDEADBEEF);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("stallKey",  keyInput, 32'h12345678);
      checkOutput("stallOk",   {31'b0, keyOk}, 32'd1);
      checkOutput("checkStartIgnored", {31'b0, busy}, 32'd0);
      @(negedge clock);
      checkOutput("stillIdle", {31'b0, busy}, 32'd0);

      // Bad checksum
      loadKey(32'hDEADBEEF, 8'h23, 0, -1);
      @(negedge clock);
      checkOutput("bad1Key",  keyInput, 32'h0);
      checkOutput("bad1Ok",   {31'b0, keyOk}, 32'd0);
      checkOutput("bad1Err",  {31'b0, err}, 32'd1);
      checkOutput("bad1Fail", {30'b0, failCnt}, 32'd1);
      checkOutput("bad1Busy", {31'b0, busy}, 32'd0);

      loadKey(32'hDEADBEEF, 8'h23, 0, -1);
      @(negedge clock);
      checkOutput("bad2Fail",   {30'b0, failCnt}, 32'd2);
      checkOutput("bad2Locked", {31'b0, locked}, 32'd0);

      loadKey(32'hCAFEF00D, 8'h00, 0, -1);
      @(negedge clock);
      checkOutput("bad3Fail", {30'b0, failCnt}, 32'd3);
      checkOutput("bad3Err",  {31'b0, err}, 32'd1);
`ifdef KEY_LOADER_LOCKOUT_EN
      checkOutput("lockOn",  {31'b0, locked}, 32'd1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      checkOutput("lockBusy",   {31'b0, busy}, 32'd0);
      checkOutput("lockReady",  {31'b0, sdiReady}, 32'd0);
      checkOutput("lockKey",    keyInput, 32'h0);
      checkOutput("lockStays",  {31'b0, locked}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("unlockRst",  {31'b0, locked}, 32'd0);
      checkOutput("unlockFail", {30'b0, failCnt}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
`else
      checkOutput("noLock", {31'b0, locked}, 32'd0);
      loadKey(32'hDEADBEEF, 8'h23, 0, -1);
      @(negedge clock);
      checkOutput("bad4FailSat", {30'b0, failCnt}, 32'd3);
      checkOutput("bad4Locked",  {31'b0, locked}, 32'd0);
`endif
      loadKey(32'hDEADBEEF, 8'h22, 0, -1);
      @(negedge clock);
      checkOutput("retryKey",  keyInput, 32'hDEADBEEF);
      checkOutput("retryOk",   {31'b0, keyOk}, 32'd1);
      checkOutput("retryFail", {30'b0, failCnt}, 32'd0);
      checkOutput("retryErr",  {31'b0, err}, 32'd0);

      // Reset after 10 bits of a new load discards everything immediately
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 0);
      checkOutput("midBusy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midRstKey",   keyInput, 32'h0);
      checkOutput("midRstOk",    {31'b0, keyOk}, 32'd0);
      checkOutput("midRstBusy",  {31'b0, busy}, 32'd0);
      checkOutput("midRstReady", {31'b0, sdiReady}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      loadKey(32'hA5A5A5A5, 8'h00, 0, -1);
      @(negedge clock);
      checkOutput("a5Key", keyInput, 32'hA5A5A5A5);
      checkOutput("a5Ok",  {31'b0, keyOk}, 32'd1);

      // Stray start pulse in the middle of SHIFT
      loadKey(32'h12345678, 8'h08, 0, 16);
      @(negedge clock);
      checkOutput("strayKey",  keyInput, 32'h12345678);
      checkOutput("strayOk",   {31'b0, keyOk}, 32'd1);
      checkOutput("strayErr",  {31'b0, err}, 32'd0);
      checkOutput("strayBusy", {31'b0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/key_loader.md
Name: key_loader

Overview:
- Sequential key-delivery controller that produces the locking-key bus consumed by the key-gated benchmark netlists (keyinput0..keyinputN-1).
- Receives a key serially, MSB first, over a valid/ready bit interface, followed by an 8-bit XOR checksum.
- On a checksum match, it drives the key bus in one atomic update.
- It is the provisioning end of the key interface: it writes the key, and the locked circuit reads it.

Parameters:
- KEY_W, 32, key width in bits; must be a multiple of 8 and at least 8.
- MAX_FAIL, 3, number of consecutive checksum failures before lockout; must be at least 1.
- CNT_W, 6, width of the bit counter; must satisfy 2^CNT_W > KEY_W+8.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- sdi  in  1  serial data bit.
- sdi_valid  in  1  sdi holds a valid bit this cycle.
- sdi_ready  out  1  loader accepts a bit this cycle.
- keyinput  out  KEY_W  key bus; keyinput[i] feeds keyinput<i> of the locked netlist.
- key_ok  out  1  keyinput holds a verified key.
- busy  out  1  a load is in progress.
- err  out  1  sticky flag: the last load failed its checksum.
- locked  out  1  lockout is active.
- fail_cnt  out  2  consecutive failure count, saturating.

Behaviour:
- Reset (asynchronous; all outputs take these values immediately):
  - keyinput=0, key_ok=0, busy=0, err=0, locked=0, fail_cnt=0, sdi_ready=0.
  - FSM goes to IDLE and the shift register clears.
- A bit transfers on a rising clk edge when sdi_valid && sdi_ready.
- sdi_ready is a registered output. It is 1 only in SHIFT and SUM, and 0 in all other states.
- FSM states:
  - IDLE: on start && !locked, go to SHIFT. Set busy=1, clear the bit counter and shift register, and clear err. keyinput and key_ok keep their values during the load.
  - SHIFT: each accepted bit does shreg <= {shreg[KEY_W-2:0], sdi} and increments the counter. After the KEY_W-th accepted bit, go to SUM.
  - SUM: shift 8 bits into sum_reg, MSB first. After the 8th accepted bit, go to CHECK.
  - CHECK (one cycle): compute calc = XOR of the KEY_W/8 bytes of shreg.
    - If calc == sum_reg: keyinput <= shreg, key_ok <= 1, fail_cnt <= 0, err <= 0.
    - If they differ: keyinput <= 0, key_ok <= 0, err <= 1, fail_cnt <= fail_cnt+1 (saturating at 3).
    - Next state is IDLE with busy=0. If the updated fail_cnt >= MAX_FAIL, next state is LOCK instead.
  - LOCK: locked=1, keyinput=0, key_ok=0. The state is absorbing; only rst exits it.
- Latency: the key becomes visible on keyinput 1 cycle after the edge that accepts the last checksum bit, at the CHECK-to-IDLE edge.
- Stalls: sdi_valid low in SHIFT or SUM stalls the FSM indefinitely. No timeout is implemented.
- start outside IDLE is ignored, including when busy or in LOCK.
- A start asserted on the same edge that enters IDLE from CHECK is not honoured. A fresh start in a later cycle is required.
- The bit counter never wraps within a load, because CNT_W is bounded by the parameter rule.
- Reset in the middle of a load discards the partial key. keyinput returns to 0 asynchronously, and the previous verified key is lost.
- keyinput never shows a partial or unverified value. It changes only at CHECK or on reset.

Optional Feature:
- Macro: KEY_LOADER_LOCKOUT_EN.
- Defined: lockout behaves as described above, using the LOCK state and the locked output.
- Undefined:
  - The LOCK state is not built and locked is tied to 0.
  - fail_cnt still counts and saturates.
  - A failed CHECK always returns to IDLE, so retries are unlimited.

Test Plan:
- Reset, then start, then send 32'hDEADBEEF followed by checksum 8'h22 with sdi_valid held high -> keyinput=32'hDEADBEEF and key_ok=1 one cycle after the last bit; err=0, busy=0.
- Send 32'h12345678 with checksum 8'h08 (correct), inserting random sdi_valid gaps -> keyinput=32'h12345678; no bits are accepted while sdi_valid=0.
- Load 32'hDEADBEEF with checksum 8'h23 (wrong) -> keyinput=0, key_ok=0, err=1, fail_cnt=1, FSM back in IDLE.
- Three consecutive bad loads with KEY_LOADER_LOCKOUT_EN defined -> locked=1 after the third CHECK; a following start is ignored (busy stays 0); only rst clears the lockout. With the macro undefined -> locked=0 and a 4th, good load succeeds.
- Complete a good load, start a new one, and assert rst after 10 bits -> all outputs go to 0 immediately; a subsequent good load with 32'hA5A5A5A5 and checksum 8'h00 succeeds.
- Pulse start in the middle of SHIFT -> it is ignored; the counter and shift register are undisturbed, and the load completes correctly.
